// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Reader side of the instruction ROM. Owns the program counter, addresses the
// ROM with it, decodes the word returned in the same cycle, resolves JMP
// locally and hands ADD/SUB/SHL/LDI to the SIMD execute lanes.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   run          fetch enable; a stop takes effect at an instruction boundary
//   pc_addr      ROM address (the PC register itself)
//   rom_data     instruction at pc_addr, combinational from the ROM
//   issue_valid  decoded instruction presented to the lanes
//   issue_ready  lanes accept the presented instruction
//   opcode/dest/src1/src2  instruction nibbles [15:12]/[11:8]/[7:4]/[3:0]
//   imm          instruction [7:0] (LDI immediate)
//   halted       sticky; set by HALT (0x0000) or an illegal opcode
//   illegal      sticky; set by an undefined opcode
//   issue_count  accepted issues, wraps at 0xFFFF
//
// Handshake: an instruction transfers on a rising edge where
// issue_valid & issue_ready. Once issue_valid is high, it and every field
// output stay constant until that transfer; only rst can withdraw it.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic [ADDR_W-1:0]   pc_addr,
  input  logic [INSTR_W-1:0]  rom_data,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [3:0]          opcode,
  output logic [3:0]          dest,
  output logic [3:0]          src1,
  output logic [3:0]          src2,
  output logic [7:0]          imm,
  output logic                halted,
  output logic                illegal,
  output logic [15:0]         issue_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_LDI  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  // Current FSM state; probe hierarchically for debug.
  state_t state;

  // Classification of the ROM word at the current PC.
  logic [3:0] rom_op;
  logic       dec_issue;
  logic       dec_jmp;
  logic       dec_halt;
  logic       dec_illegal;

  always_comb begin
    rom_op      = rom_data[15:12];
    dec_issue   = 1'b0;
    dec_jmp     = 1'b0;
    dec_halt    = 1'b0;
    dec_illegal = 1'b0;
    case (rom_op)
      OP_ADD, OP_SUB, OP_SHL, OP_LDI: dec_issue = 1'b1;
      OP_JMP:                         dec_jmp   = 1'b1;
      OP_HALT:                        dec_halt  = 1'b1;
      default:                        dec_illegal = 1'b1;
    endcase
  end

  // "Evaluate" is needed from both FETCH and a completed ISSUE handshake, so
  // the decision is computed once here and applied in both places.
  logic handshake;
  assign handshake = issue_valid & issue_ready;

  logic do_eval;
  always_comb begin
    do_eval = 1'b0;
    case (state)
      ST_FETCH: do_eval = run;
      ST_ISSUE: do_eval = handshake & run;
      default:  do_eval = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc_addr     <= ADDR_W'(RESET_PC);
      issue_valid <= 1'b0;
      opcode      <= 4'd0;
      dest        <= 4'd0;
      src1        <= 4'd0;
      src2        <= 4'd0;
      imm         <= 8'd0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      issue_count <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (!run) state <= ST_IDLE;
        end
        ST_ISSUE: begin
          if (handshake) begin
            issue_count <= issue_count + 16'd1;
            if (!run) begin
              issue_valid <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end
        default: ; // ST_HALT: absorbing until rst
      endcase

      // Evaluate overrides the per-state defaults above when it fires.
      if (do_eval) begin
        if (dec_issue) begin
          opcode      <= rom_data[15:12];
          dest        <= rom_data[11:8];
          src1        <= rom_data[7:4];
          src2        <= rom_data[3:0];
          imm         <= rom_data[7:0];
          issue_valid <= 1'b1;
          pc_addr     <= pc_addr + 1'b1;  // wraps modulo 2^ADDR_W
          state       <= ST_ISSUE;
        end else if (dec_jmp) begin
          // Jump costs one bubble: the target is read in the next FETCH.
          pc_addr     <= ADDR_W'(rom_data[7:0]);
          issue_valid <= 1'b0;
          state       <= ST_FETCH;
        end else begin
          // HALT or illegal: PC is left pointing at the offending word.
          issue_valid <= 1'b0;
          halted      <= 1'b1;
          illegal     <= illegal | dec_illegal;
          state       <= ST_HALT;
        end
      end
    end
  end

  // dec_halt is implied by the final else branch; kept for readability.
  logic unused_dec_halt;
  assign unused_dec_halt = dec_halt;

endmodule
